// File: rtl/seq_mul_unit.sv
// Iterative shift-and-add multiplier for the execute path: one partial product per cycle,
// sign handled by magnitude/negate, selected product byte returned through the register-file write port.
module seq_mul_unit #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [WIDTH-1:0]  DATA1,
    input  logic [WIDTH-1:0]  DATA2,
    input  logic [ADDR_W-1:0] DEST,
    input  logic              SIGNED_OP,
    input  logic              HIGH_SEL,
    output logic              BUSY,
    output logic [WIDTH-1:0]  RESULT,
    output logic              WRITE_EN,
    output logic [ADDR_W-1:0] WRITE_ADDR,
    output logic              DONE
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic                   r_sign;
    logic                   r_high_sel;

    logic                   w_last;
    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_acc_shift;
    logic [2*WIDTH-1:0]     w_product;

    // Two's-complement magnitude of an operand; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic neg);
        return neg ? (~p + (2*WIDTH)'(1)) : p;
    endfunction

    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_addend    = r_mplier[0] ? r_mcand : '0;
    assign w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    // The adder carry becomes the new MSB as the accumulator shifts right.
    assign w_acc_shift = {w_sum, r_acc[WIDTH-1:1]};
    assign w_product   = apply_sign(w_acc_shift, r_sign);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (START) w_next_state = S_CALC;
            S_CALC:  if (w_last) w_next_state = S_WB;
            S_WB:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt      <= '0;
            BUSY       <= 1'b0;
            RESULT     <= '0;
            WRITE_EN   <= 1'b0;
            WRITE_ADDR <= '0;
            DONE       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    WRITE_EN <= 1'b0;
                    DONE     <= 1'b0;
                    if (START) begin
                        r_mcand    <= magnitude(DATA1, SIGNED_OP);
                        r_mplier   <= magnitude(DATA2, SIGNED_OP);
                        r_sign     <= SIGNED_OP & (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
                        r_high_sel <= HIGH_SEL;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        WRITE_ADDR <= DEST;
                        BUSY       <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_shift;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        RESULT   <= r_high_sel ? w_product[2*WIDTH-1:WIDTH] : w_product[WIDTH-1:0];
                        WRITE_EN <= 1'b1;
                        DONE     <= 1'b1;
                    end
                end
                S_WB: begin
                    WRITE_EN <= 1'b0;
                    DONE     <= 1'b0;
                    BUSY     <= 1'b0;
                end
                default: begin
                    WRITE_EN <= 1'b0;
                    DONE     <= 1'b0;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Scoreboard bench for seq_mul_unit: expected writes are queued at issue and checked when WRITE_EN fires.
module tb_seq_mul_unit;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [7:0] DATA1 = '0;
    logic [7:0] DATA2 = '0;
    logic [2:0] DEST = '0;
    logic       SIGNED_OP = 1'b0;
    logic       HIGH_SEL = 1'b0;
    logic       BUSY;
    logic [7:0] RESULT;
    logic       WRITE_EN;
    logic [2:0] WRITE_ADDR;
    logic       DONE;

    typedef struct {
        logic [7:0] res;
        logic [2:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_writes = 0;
    int   last_we_cyc = -1;

    seq_mul_unit #(.WIDTH(8), .ADDR_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
        .DEST(DEST), .SIGNED_OP(SIGNED_OP), .HIGH_SEL(HIGH_SEL), .BUSY(BUSY),
        .RESULT(RESULT), .WRITE_EN(WRITE_EN), .WRITE_ADDR(WRITE_ADDR), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    // Write-port monitor: every WRITE_EN pulse must match the oldest queued expectation.
    initial forever begin
        exp_t e;
        @(negedge CLK);
        if (WRITE_EN === 1'b1 || DONE === 1'b1) begin
            total++;
            if (DONE !== WRITE_EN) begin
                bad++;
                $display("FAIL done_vs_we: DONE=%b WRITE_EN=%b, required equal", DONE, WRITE_EN);
            end
        end
        if (WRITE_EN === 1'b1) begin
            n_writes++;
            last_we_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: RESULT=%02h ADDR=%0d, required no write", RESULT, WRITE_ADDR);
            end else begin
                e = exp_q.pop_front();
                if (RESULT !== e.res) begin
                    bad++;
                    $display("FAIL wb_result: got %02h, required %02h", RESULT, e.res);
                end
                total++;
                if (WRITE_ADDR !== e.addr) begin
                    bad++;
                    $display("FAIL wb_addr: got %0d, required %0d", WRITE_ADDR, e.addr);
                end
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        int g = 0;
        while (cyc < t && g < 200) begin
            step();
            g++;
        end
    endtask

    // Drive one START cycle; c0 is the cycle count just before the sampling edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] d,
                         input logic s, input logic h, input bit accept, output int c0);
        logic [15:0] p;
        exp_t e;
        if (s) p = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
        else   p = {8'h00, a} * {8'h00, b};
        DATA1 = a; DATA2 = b; DEST = d; SIGNED_OP = s; HIGH_SEL = h;
        START = 1'b1;
        c0 = cyc;
        if (accept) begin
            e.res  = h ? p[15:8] : p[7:0];
            e.addr = d;
            exp_q.push_back(e);
        end
        step();
        START = 1'b0;
    endtask

    task automatic wait_write(input int prev, input int limit);
        int t = 0;
        while (n_writes == prev && t < limit) begin
            step();
            t++;
        end
        total++;
        if (n_writes == prev) begin
            bad++;
            $display("FAIL write_timeout: no WRITE_EN within %0d cycles, required one", limit);
        end
        step();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) step();
        RESET = 1'b0;
        total++; if (BUSY !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b, required 0", BUSY); end
        total++; if (RESULT !== 8'h00)   begin bad++; $display("FAIL rst_result: got %02h, required 00", RESULT); end
        total++; if (WRITE_EN !== 1'b0)  begin bad++; $display("FAIL rst_we: got %b, required 0", WRITE_EN); end
        total++; if (WRITE_ADDR !== 3'd0) begin bad++; $display("FAIL rst_addr: got %0d, required 0", WRITE_ADDR); end
        total++; if (DONE !== 1'b0)      begin bad++; $display("FAIL rst_done: got %b, required 0", DONE); end
        // START together with RESET must not be accepted.
        RESET = 1'b1; START = 1'b1; DATA1 = 8'h03; DATA2 = 8'h03;
        step();
        RESET = 1'b0; START = 1'b0;
        step();
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL start_with_reset: BUSY=%b, required 0", BUSY); end
    endtask

    task automatic test_unsigned_basic();
        int c0, bc, nw;
        nw = n_writes;
        issue(8'd7, 8'd6, 3'd3, 1'b0, 1'b0, 1'b1, c0);
        bc = 0;
        while (BUSY === 1'b1 && bc < 20) begin
            bc++;
            step();
        end
        total++; if (bc !== 9) begin bad++; $display("FAIL busy_len: got %0d cycles, required 9", bc); end
        total++; if (n_writes !== nw + 1) begin bad++; $display("FAIL basic_writes: got %0d, required %0d", n_writes - nw, 1); end
        total++; if (last_we_cyc !== c0 + 9) begin bad++; $display("FAIL basic_latency: write at %0d, required %0d", last_we_cyc, c0 + 9); end
        total++; if (RESULT !== 8'h2A) begin bad++; $display("FAIL result_hold: got %02h, required 2a", RESULT); end
    endtask

    task automatic test_products();
        int c0;
        logic [7:0] ta [6] = '{8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'h80, 8'h80};
        logic [7:0] tb [6] = '{8'hFF, 8'hFF, 8'h05, 8'h05, 8'h80, 8'h80};
        logic       ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       th [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            int nw = n_writes;
            issue(ta[i], tb[i], 3'(i + 1), ts[i], th[i], 1'b1, c0);
            wait_write(nw, 15);
            step();
        end
        // Independent anchor values for the signed corner case.
        total++; if (RESULT !== 8'h40) begin bad++; $display("FAIL neg128_sq_high: got %02h, required 40", RESULT); end
    endtask

    task automatic test_back_to_back();
        int c0, nw;
        nw = n_writes;
        issue(8'd2, 8'd3, 3'd5, 1'b0, 1'b0, 1'b1, c0);
        wait_cyc(c0 + 4);
        DATA1 = 8'd9; DATA2 = 8'd9; DEST = 3'd7; START = 1'b1;
        step();
        START = 1'b0;
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b, required 1", BUSY); end
        wait_cyc(c0 + 9);
        total++; if (WRITE_EN !== 1'b1) begin bad++; $display("FAIL b2b_wb_cycle: WRITE_EN=%b, required 1", WRITE_EN); end
        START = 1'b1;
        step();
        START = 1'b0;
        repeat (15) step();
        total++; if (n_writes !== nw + 1) begin bad++; $display("FAIL b2b_writes: got %0d, required 1", n_writes - nw); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL b2b_idle: BUSY=%b, required 0", BUSY); end
        total++; if (RESULT !== 8'h06) begin bad++; $display("FAIL b2b_result: got %02h, required 06", RESULT); end
        total++; if (WRITE_ADDR !== 3'd5) begin bad++; $display("FAIL b2b_addr: got %0d, required 5", WRITE_ADDR); end
    endtask

    task automatic test_reset_abort();
        int c0, nw;
        nw = n_writes;
        issue(8'd10, 8'd10, 3'd6, 1'b0, 1'b0, 1'b0, c0);
        wait_cyc(c0 + 4);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        total++; if (BUSY !== 1'b0)     begin bad++; $display("FAIL abort_busy: got %b, required 0", BUSY); end
        total++; if (RESULT !== 8'h00)  begin bad++; $display("FAIL abort_result: got %02h, required 00", RESULT); end
        total++; if (WRITE_ADDR !== 3'd0) begin bad++; $display("FAIL abort_addr: got %0d, required 0", WRITE_ADDR); end
        repeat (12) step();
        total++; if (n_writes !== nw) begin bad++; $display("FAIL abort_no_write: got %0d writes, required 0", n_writes - nw); end
    endtask

    task automatic test_idle_restart();
        int c0, c1, we1, nw;
        nw = n_writes;
        issue(8'h00, 8'h55, 3'd2, 1'b0, 1'b0, 1'b1, c0);
        wait_cyc(c0 + 10);
        we1 = last_we_cyc;
        total++; if (we1 !== c0 + 9) begin bad++; $display("FAIL zero_latency: write at %0d, required %0d", we1, c0 + 9); end
        total++; if (RESULT !== 8'h00) begin bad++; $display("FAIL zero_result: got %02h, required 00", RESULT); end
        issue(8'h10, 8'h10, 3'd4, 1'b0, 1'b1, 1'b1, c1);
        wait_write(nw + 1, 15);
        total++; if (last_we_cyc - we1 !== 10) begin bad++; $display("FAIL restart_spacing: got %0d cycles, required 10", last_we_cyc - we1); end
        total++; if (RESULT !== 8'h01) begin bad++; $display("FAIL restart_result: got %02h, required 01", RESULT); end
    endtask

    initial begin
        step();
        test_reset();
        test_unsigned_basic();
        test_products();
        test_back_to_back();
        test_reset_abort();
        test_idle_restart();
        repeat (3) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_writes: %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
